// File: rtl/lcd_bus_reader.sv
// lcd_bus_reader: read-side engine for an HD44780-compatible LCD bus.
// Each accepted request runs one timed read cycle: RS/RW setup, EN strobe, RS/RW hold.
// RS=0 returns busy flag + address counter, RS=1 returns a DDRAM/CGRAM byte.
// Optional busy-flag polling is compiled in when BUSY_POLL_EN is defined.
module lcd_bus_reader #(
  parameter int T_AS     = 3,
  parameter int T_EN     = 16,
  parameter int T_H      = 2,
  parameter int POLL_GAP = 500,
  parameter int POLL_MAX = 255
) (
  input  logic       CLOCK_50,
  input  logic       RST_N,
  input  logic       req_valid,
  input  logic       req_rs,
  output logic       req_ready,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_busy,
  output logic [6:0] rsp_addr,
  input  logic       poll_start,
  output logic       poll_done,
  output logic       poll_timeout,
  output logic       LCD_EN,
  output logic       LCD_RS,
  output logic       LCD_RW,
  input  logic [7:0] LCD_DATA_IN
);

  localparam logic [7:0] AS_LOAD = 8'(T_AS - 1);
  localparam logic [7:0] EN_LOAD = 8'(T_EN - 1);
  localparam logic [7:0] H_LOAD  = 8'(T_H - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    EN_HI,
`ifdef BUSY_POLL_EN
    HOLD,
    POLL_WAIT
`else
    HOLD
`endif
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       rs_q, rs_d;
  logic [7:0] byte_q, byte_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       rsp_busy_q, rsp_busy_d;
  logic [6:0] rsp_addr_q, rsp_addr_d;

  logic accept;
  logic poll_go;
  logic start;
  logic cnt_zero;
  logic last_en;
  logic last_hold;

  assign accept    = req_ready && req_valid;
  assign start     = poll_go || accept;
  assign cnt_zero  = (cnt_q == 8'd0);
  assign last_en   = (state_q == EN_HI) && cnt_zero;
  assign last_hold = (state_q == HOLD) && cnt_zero;

`ifdef BUSY_POLL_EN
  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(POLL_GAP - 1);
  localparam logic [7:0]       POLL_LAST = 8'(POLL_MAX - 1);

  logic             poll_mode_q, poll_mode_d;
  logic [7:0]       poll_cnt_q, poll_cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             poll_done_q, poll_done_d;
  logic             poll_timeout_q, poll_timeout_d;
  logic             poll_again;

  // poll_start wins over req_valid when both arrive in IDLE
  assign poll_go    = req_ready && poll_start;
  assign poll_again = poll_mode_q && byte_q[7] && (poll_cnt_q != POLL_LAST);
`else
  logic [8:0] unused_poll;

  assign poll_go     = 1'b0;
  assign unused_poll = {poll_start, 8'(POLL_GAP) ^ 8'(POLL_MAX)};
`endif

  // State register
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: each timed phase exits when its down-counter reaches zero
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = SETUP;
      SETUP: if (cnt_zero) state_d = EN_HI;
      EN_HI: if (cnt_zero) state_d = HOLD;
      HOLD: begin
        if (cnt_zero) begin
`ifdef BUSY_POLL_EN
          state_d = poll_again ? POLL_WAIT : IDLE;
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef BUSY_POLL_EN
      POLL_WAIT: if (gap_q == '0) state_d = SETUP;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; LCD_EN therefore drops the instant reset asserts
  always_comb begin
    LCD_EN    = (state_q == EN_HI);
    LCD_RW    = (state_q == SETUP) || (state_q == EN_HI) || (state_q == HOLD);
    LCD_RS    = LCD_RW && rs_q;
    req_ready = RST_N && (state_q == IDLE) && !rsp_valid_q;
  end

  // Phase counter is reloaded with the phase length minus one on every state change
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      case (state_d)
        SETUP:   cnt_d = AS_LOAD;
        EN_HI:   cnt_d = EN_LOAD;
        HOLD:    cnt_d = H_LOAD;
        default: cnt_d = 8'd0;
      endcase
    end else if (!cnt_zero) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  // Latch RS on accept, sample the pad on the last EN cycle, publish the response after HOLD
  always_comb begin
    rs_d        = rs_q;
    byte_d      = byte_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_busy_d  = rsp_busy_q;
    rsp_addr_d  = rsp_addr_q;
    if (poll_go)     rs_d = 1'b0;
    else if (accept) rs_d = req_rs;
    if (last_en) byte_d = LCD_DATA_IN;
    if (last_hold) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = byte_q;
      rsp_busy_d  = !rs_q && byte_q[7];
      rsp_addr_d  = rs_q ? 7'd0 : byte_q[6:0];
    end
  end

  // Datapath registers
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q       <= 8'd0;
      rs_q        <= 1'b0;
      byte_q      <= 8'd0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'd0;
      rsp_busy_q  <= 1'b0;
      rsp_addr_q  <= 7'd0;
    end else begin
      cnt_q       <= cnt_d;
      rs_q        <= rs_d;
      byte_q      <= byte_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_busy_q  <= rsp_busy_d;
      rsp_addr_q  <= rsp_addr_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_busy  = rsp_busy_q;
  assign rsp_addr  = rsp_addr_q;

`ifdef BUSY_POLL_EN
  // Poll bookkeeping: count busy reads, time the gap, flag done or timeout with the final response
  always_comb begin
    poll_mode_d    = poll_mode_q;
    poll_cnt_d     = poll_cnt_q;
    gap_d          = gap_q;
    poll_done_d    = 1'b0;
    poll_timeout_d = 1'b0;
    if (poll_go) begin
      poll_mode_d = 1'b1;
      poll_cnt_d  = 8'd0;
    end
    if (last_hold && poll_mode_q) begin
      if (byte_q[7]) poll_cnt_d = poll_cnt_q + 8'd1;
      poll_done_d    = !byte_q[7];
      poll_timeout_d = byte_q[7] && !poll_again;
      poll_mode_d    = poll_again;
    end
    if ((state_d == POLL_WAIT) && (state_q != POLL_WAIT)) gap_d = GAP_LOAD;
    else if (gap_q != '0)                                 gap_d = gap_q - GAP_W'(1);
  end

  // Poll registers
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      poll_mode_q    <= 1'b0;
      poll_cnt_q     <= 8'd0;
      gap_q          <= '0;
      poll_done_q    <= 1'b0;
      poll_timeout_q <= 1'b0;
    end else begin
      poll_mode_q    <= poll_mode_d;
      poll_cnt_q     <= poll_cnt_d;
      gap_q          <= gap_d;
      poll_done_q    <= poll_done_d;
      poll_timeout_q <= poll_timeout_d;
    end
  end

  assign poll_done    = poll_done_q;
  assign poll_timeout = poll_timeout_q;
`else
  assign poll_done    = 1'b0;
  assign poll_timeout = 1'b0;
`endif

endmodule
